// File: rtl/riscv_pkg.sv
// Shared memory-interface types: arbiter FSM states and MemSize codes,
// also used by the load/store decoder.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_INVALID = 2'b11
  } mem_size_t;

endpackage

// File: rtl/mem_align_check.sv
// Flags data accesses whose size code is invalid or whose address is not
// naturally aligned for that size.
module mem_align_check
  import riscv_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic       o_err
);

  always_comb begin
    o_err = 1'b0;
    case (mem_size_t'(i_size))
      MEM_BYTE:    o_err = 1'b0;
      MEM_HALF:    o_err = i_addr_lo[0];
      MEM_WORD:    o_err = |i_addr_lo;
      MEM_INVALID: o_err = 1'b1;
      default:     o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch and data access; data has priority unless fetch has been starved.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDRESS_BITS = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDRESS_BITS-1:0] if_addr,
  output logic [31:0]             if_rdata,
  output logic                    if_done,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [1:0]              d_size,
  input  logic [ADDRESS_BITS-1:0] d_addr,
  input  logic [31:0]             d_wdata,
  output logic [31:0]             d_rdata,
  output logic                    d_done,
  output logic                    d_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [1:0]              mem_size,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t              r_state;
  arb_state_t              w_next;
  logic [CNT_W-1:0]        r_starve;
  logic                    r_is_fetch;
  logic                    r_we;
  logic                    r_err;
  logic [1:0]              r_size;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_if_rdata;
  logic [31:0]             r_d_rdata;

  logic w_misaligned;
  logic w_fetch_forced;
  logic w_grant_d;
  logic w_grant_f;

  mem_align_check u_align (
    .i_size    (d_size),
    .i_addr_lo (d_addr[1:0]),
    .o_err     (w_misaligned)
  );

  assign w_fetch_forced = if_req && (r_starve == CNT_W'(STARVE_LIMIT));
  assign w_grant_d      = d_req && !w_fetch_forced;
  assign w_grant_f      = if_req && !w_grant_d;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d)      w_next = w_misaligned ? RESP : ISSUE;
        else if (w_grant_f) w_next = ISSUE;
      end
      ISSUE:   w_next = WAIT;
      WAIT:    if (mem_ready) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_is_fetch <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_grant_d) begin
          r_is_fetch <= 1'b0;
          r_we       <= d_we;
          r_size     <= d_size;
          r_addr     <= d_addr;
          r_wdata    <= d_wdata;
          r_err      <= w_misaligned;
          // Starvation only accumulates while fetch is actually waiting.
          if (!if_req)
            r_starve <= '0;
          else if (r_starve != CNT_W'(STARVE_LIMIT))
            r_starve <= r_starve + 1'b1;
          if (w_misaligned)
            r_d_rdata <= '0;
        end else if (w_grant_f) begin
          r_is_fetch <= 1'b1;
          r_we       <= 1'b0;
          r_size     <= MEM_WORD;
          r_addr     <= if_addr;
          r_wdata    <= '0;
          r_err      <= 1'b0;
          r_starve   <= '0;
        end
      end
      if (r_state == WAIT && mem_ready) begin
        if (r_is_fetch) r_if_rdata <= mem_rdata;
        else            r_d_rdata  <= r_we ? 32'd0 : mem_rdata;
      end
    end
  end

  assign mem_en    = (r_state == ISSUE);
  assign mem_we    = mem_en && r_we;
  assign mem_size  = r_size;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_done   = (r_state == RESP) && r_is_fetch;
  assign d_done    = (r_state == RESP) && !r_is_fetch;
  assign d_err     = d_done && r_err;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_done;
  logic          d_err;
  logic          mem_en;
  logic          mem_we;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;

  mem_port_arbiter #(.ADDRESS_BITS(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_str(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s', want '%s'", name, act, exp);
    end
  endfunction

  function automatic bit misaligned(logic [1:0] sz, logic [31:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return (a % 2) != 0;
      2'b10:   return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy = 0;
  bit          m_fetch = 0;
  bit          m_we = 0;
  bit          m_err = 0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata = '0;
  int          m_starve = 0;
  int          m_en_cyc = -1;
  int          m_done_cyc = -1;
  int          m_grant_cyc = 0;
  bit          e_en, e_done;

  always @(negedge clock) begin
    if (reset) begin
      m_busy = 0; m_starve = 0; m_if_rdata = '0; m_d_rdata = '0;
      m_en_cyc = -1; m_done_cyc = -1;
    end else begin
      e_en   = m_busy && (cyc == m_en_cyc);
      e_done = m_busy && (cyc == m_done_cyc);
      if (e_done) begin
        if (m_fetch) m_if_rdata = m_rd;
        else         m_d_rdata  = (m_we || m_err) ? 32'd0 : m_rd;
      end
      chk("mem_en",   64'(mem_en),   64'(e_en));
      chk("mem_we",   64'(mem_we),   64'(e_en && m_we));
      chk("if_done",  64'(if_done),  64'(e_done && m_fetch));
      chk("d_done",   64'(d_done),   64'(e_done && !m_fetch));
      chk("d_err",    64'(d_err),    64'(e_done && !m_fetch && m_err));
      chk("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
      chk("d_rdata",  64'(d_rdata),  64'(m_d_rdata));
      if (e_en) begin
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_size", 64'(mem_size), 64'(m_size));
        if (m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      if (!m_busy) begin
        if (d_req && !(if_req && m_starve == LIMIT)) begin
          m_busy = 1; m_fetch = 0; m_we = d_we; m_size = d_size;
          m_addr = d_addr; m_wdata = d_wdata; m_err = misaligned(d_size, d_addr);
          m_starve = if_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end else if (if_req) begin
          m_busy = 1; m_fetch = 1; m_we = 0; m_size = 2'b10;
          m_addr = if_addr; m_wdata = '0; m_err = 0; m_starve = 0;
        end
        if (m_busy) begin
          m_grant_cyc = cyc;
          m_done_cyc  = m_err ? cyc + 1 : -1;
          m_en_cyc    = m_err ? -1 : cyc + 1;
        end
      end else if (e_done) begin
        m_busy = 0;
      end else if (m_done_cyc < 0 && cyc > m_en_cyc && mem_ready) begin
        m_done_cyc = cyc + 1;
        m_rd = mem_rdata;
      end else if (cyc - m_grant_cyc > 200) begin
        checks++; errors++;
        $display("FAIL txn_timeout: granted at cycle %0d, still open at %0d", m_grant_cyc, cyc);
        m_busy = 0;
      end
    end
  end

  // ---------------- memory responder ----------------
  bit          rsp_random = 0;
  int          rsp_delay = 1;
  logic [31:0] rsp_data = '0;
  bit          rsp_pend = 0;
  int          rsp_cnt = 0;

  initial begin
    mem_ready = 0; mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      mem_ready = 0;
      if (rsp_random) begin
        mem_ready = ($urandom_range(0, 2) == 0);
        mem_rdata = $urandom;
        rsp_pend  = 0;
      end else if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          mem_ready = 1; mem_rdata = rsp_data; rsp_pend = 0;
        end else rsp_cnt--;
      end
      if (mem_en && !rsp_random) begin
        rsp_pend = 1; rsp_cnt = rsp_delay - 1;
      end
    end
  end

  // ---------------- requesters ----------------
  typedef struct { logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; bit b2b; } dreq_t;
  typedef struct { logic [31:0] addr; bit b2b; } freq_t;
  dreq_t dq[$];
  freq_t fq[$];
  dreq_t tmp_d;
  freq_t tmp_f;

  bit          rand_gap = 0;
  int          f_req_cyc = 0, d_req_cyc = 0;
  int          en_cyc_log = 0, ifdone_cyc_log = 0, ddone_cyc_log = 0, en_count = 0;
  bit          first_en_seen = 0;
  logic [31:0] first_en_addr = '0;
  logic [31:0] s_if_rdata = '0, s_d_rdata = '0;
  bit          s_d_err = 0;
  string       order_s = "";

  task automatic push_d(logic we, logic [1:0] sz, logic [31:0] a, logic [31:0] wd, bit b2b);
    tmp_d.we = we; tmp_d.size = sz; tmp_d.addr = a; tmp_d.wdata = wd; tmp_d.b2b = b2b;
    dq.push_back(tmp_d);
  endtask

  task automatic push_f(logic [31:0] a, bit b2b);
    tmp_f.addr = a; tmp_f.b2b = b2b;
    fq.push_back(tmp_f);
  endtask

  task automatic present_fetch();
    freq_t e;
    e = fq.pop_front();
    if_req = 1; if_addr = e.addr; f_req_cyc = cyc;
  endtask

  task automatic present_data();
    dreq_t e;
    e = dq.pop_front();
    d_req = 1; d_we = e.we; d_size = e.size; d_addr = e.addr; d_wdata = e.wdata;
    d_req_cyc = cyc;
  endtask

  task automatic tick();
    bit fd, dd;
    @(negedge clock);
    fd = if_done; dd = d_done;
    if (mem_en) begin
      en_count++; en_cyc_log = cyc;
      if (!first_en_seen) begin first_en_seen = 1; first_en_addr = mem_addr; end
    end
    if (fd) begin ifdone_cyc_log = cyc; s_if_rdata = if_rdata; order_s = {order_s, "F"}; end
    if (dd) begin ddone_cyc_log = cyc; s_d_rdata = d_rdata; s_d_err = d_err; order_s = {order_s, "D"}; end
    @(posedge clock); #1;
    if (if_req && fd) begin
      if_req = 0;
      if (fq.size() > 0 && fq[0].b2b) present_fetch();
    end else if (!if_req && fq.size() > 0 && (!rand_gap || $urandom_range(0, 1) == 1))
      present_fetch();
    if (d_req && dd) begin
      d_req = 0;
      if (dq.size() > 0 && dq[0].b2b) present_data();
    end else if (!d_req && dq.size() > 0 && (!rand_gap || $urandom_range(0, 1) == 1))
      present_data();
  endtask

  task automatic run_until_idle(int maxc);
    int n;
    n = 0;
    tick();
    while ((if_req || d_req || fq.size() > 0 || dq.size() > 0) && n < maxc) begin
      tick(); n++;
    end
    chk("drain_in_time", 64'(n < maxc), 64'(1));
    tick(); tick();
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_mem_en"},    64'(mem_en),    64'(0));
    chk({tag, "_mem_we"},    64'(mem_we),    64'(0));
    chk({tag, "_mem_size"},  64'(mem_size),  64'(0));
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_if_done"},   64'(if_done),   64'(0));
    chk({tag, "_d_done"},    64'(d_done),    64'(0));
    chk({tag, "_d_err"},     64'(d_err),     64'(0));
    chk({tag, "_if_rdata"},  64'(if_rdata),  64'(0));
    chk({tag, "_d_rdata"},   64'(d_rdata),   64'(0));
  endtask

  initial begin
    int n;
    reset = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_size = '0;
    d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk_outputs_zero("reset");

    // Fetch only, memory answers one cycle after mem_en
    rsp_delay = 1; rsp_data = 32'h0050_0093;
    push_f(32'h100, 0);
    run_until_idle(50);
    chk("fetch_en_latency",   64'(en_cyc_log - f_req_cyc),     64'(1));
    chk("fetch_done_latency", 64'(ifdone_cyc_log - f_req_cyc), 64'(3));
    chk("fetch_rdata",        64'(s_if_rdata),                 64'(32'h0050_0093));

    // Simultaneous requests: data first
    order_s = ""; first_en_seen = 0; rsp_data = 32'h1234_5678;
    push_d(1'b0, 2'b10, 32'h200, 32'h0, 0);
    push_f(32'h104, 0);
    run_until_idle(60);
    chk_str("arb_order", order_s, "DF");
    chk("first_mem_addr", 64'(first_en_addr), 64'(32'h200));
    chk("load_rdata",     64'(s_d_rdata),     64'(32'h1234_5678));

    // Misaligned halfword store
    en_count = 0;
    push_d(1'b1, 2'b01, 32'h203, 32'hA5A5_A5A5, 0);
    run_until_idle(20);
    chk("err_done_latency", 64'(ddone_cyc_log - d_req_cyc), 64'(1));
    chk("err_flag",         64'(s_d_err),                  64'(1));
    chk("err_no_mem_en",    64'(en_count),                 64'(0));
    chk("err_rdata",        64'(s_d_rdata),                64'(0));

    // Starvation: data held continuously while fetch waits
    order_s = "";
    for (int i = 0; i < 10; i++) push_d(1'b0, 2'b10, 32'h400 + 32'(i * 4), 32'h0, 1);
    push_f(32'h500, 1);
    push_f(32'h504, 1);
    run_until_idle(400);
    chk_str("starve_order", order_s, "DDDDFDDDDFDD");

    // Reset while waiting on memory, stale mem_ready right after
    rsp_delay = 2; order_s = ""; first_en_seen = 0;
    push_f(32'h300, 0);
    n = 0;
    while (!first_en_seen && n < 20) begin tick(); n++; end
    chk("rst_reached_issue", 64'(first_en_seen), 64'(1));
    reset = 1; if_req = 0; fq.delete();
    tick();
    reset = 0;
    @(negedge clock);
    chk_outputs_zero("rst_mid");
    tick(); tick(); tick();
    chk_outputs_zero("rst_after");
    chk_str("rst_no_done", order_s, "");

    // Random traffic with stray mem_ready pulses
    rsp_random = 1; rand_gap = 1;
    for (int i = 0; i < 120; i++) begin
      tmp_d.addr = $urandom;
      if ($urandom_range(0, 1) == 1) tmp_d.addr[1:0] = 2'b00;
      push_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), tmp_d.addr,
             $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 80; i++)
      push_f($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
    run_until_idle(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
